controller_poller: RTL

- Upstream input stage that feeds InputCollector and the top-level button wires.
- Once per trigger (frame_end), it drives latch and clock to a NES or SNES pad, shifts in 16 serial bits and auto-detects the pad type.
- Publishes a debounced-by-frame, active-high 12-bit button word with a one-cycle valid strobe.
- Replaces the per-pin button outputs of the current controller front end with one canonical bus.

---
 rtl/controller_poller_pkg.sv | 32 +++
 rtl/controller_poller_remap.sv | 37 +++
 rtl/controller_poller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/controller_poller_pkg.sv
// Shared types and constants for the NES/SNES pad poller and its consumers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package controller_poller_pkg;

  // Poll sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } poll_state_t;

  localparam int NUM_BUTTONS = 12;
  localparam int RAW_BITS    = 16;

  // Canonical button word layout, active-high
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_X      = 8;
  localparam int BTN_Y      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

endpackage

// File: rtl/controller_poller_remap.sv
// Maps 16 active-high raw pad bits to pad type and the canonical button word.
// Latency: purely combinational.
// Backpressure: none.
module controller_poller_remap
  import controller_poller_pkg::*;
(
  input  logic [RAW_BITS-1:0]    raw,
  output logic                   is_snes,
  output logic [NUM_BUTTONS-1:0] buttons
);

  logic snes;

  // A NES pad shifts ground after bit 7 (raw=1), a SNES pad reads released on 12..15
  always_comb begin
    snes    = (raw[15:12] == 4'b0000);
    buttons = '0;
    if (snes) begin
      buttons[BTN_B]      = raw[0];
      buttons[BTN_Y]      = raw[1];
      buttons[BTN_SELECT] = raw[2];
      buttons[BTN_START]  = raw[3];
      buttons[BTN_UP]     = raw[4];
      buttons[BTN_DOWN]   = raw[5];
      buttons[BTN_LEFT]   = raw[6];
      buttons[BTN_RIGHT]  = raw[7];
      buttons[BTN_A]      = raw[8];
      buttons[BTN_X]      = raw[9];
      buttons[BTN_L]      = raw[10];
      buttons[BTN_R]      = raw[11];
    end else begin
      buttons[BTN_RIGHT:BTN_A] = raw[7:0];
    end
    is_snes = snes;
  end

endmodule

// File: rtl/controller_poller.sv
// Polls a NES/SNES pad once per trigger and publishes a 12-bit button word.
// Latency: LATCH_CYCLES + NUM_BITS*2*HALF_CYCLES + 2 cycles from trigger to valid.
// Backpressure: none; triggers arriving while busy (including DONE) are dropped.
module controller_poller
  import controller_poller_pkg::*;
#(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150,
  parameter int NUM_BITS     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic                   pad_data,
  output logic                   pad_latch,
  output logic                   pad_clk,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   is_snes,
  output logic                   valid,
  output logic                   busy
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  poll_state_t             state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [RAW_BITS-1:0]     shreg, shreg_nxt;
  logic                    latch_nxt, clk_nxt, snes_nxt, valid_nxt, busy_nxt;
  logic [NUM_BUTTONS-1:0]  buttons_nxt;
  logic                    map_snes;
  logic [NUM_BUTTONS-1:0]  map_buttons;

  // Pad data is active-low; invert before decoding
  controller_poller_remap u_remap (
    .raw     (~shreg),
    .is_snes (map_snes),
    .buttons (map_buttons)
  );

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      buttons   <= '0;
      is_snes   <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      pad_latch <= latch_nxt;
      pad_clk   <= clk_nxt;
      buttons   <= buttons_nxt;
      is_snes   <= snes_nxt;
      valid     <= valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and output sequencing of one latch/shift poll
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    latch_nxt   = pad_latch;
    clk_nxt     = pad_clk;
    buttons_nxt = buttons;
    snes_nxt    = is_snes;
    valid_nxt   = 1'b0;
    busy_nxt    = busy;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_nxt = ST_LATCH;
          latch_nxt = 1'b1;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      ST_LATCH: begin
        if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
          state_nxt = ST_LOW;
          latch_nxt = 1'b0;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt == CNT_W'(HALF_CYCLES - 1)) begin
          // Sample at the end of the low phase, when the pad output has settled
          shreg_nxt[idx] = pad_data;
          state_nxt      = ST_HIGH;
          clk_nxt        = 1'b1;
          cnt_nxt        = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt == CNT_W'(HALF_CYCLES - 1)) begin
          clk_nxt = 1'b0;
          cnt_nxt = '0;
          if (idx == IDX_W'(NUM_BITS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = ST_LOW;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        buttons_nxt = map_buttons;
        snes_nxt    = map_snes;
        valid_nxt   = 1'b1;
        busy_nxt    = 1'b0;
        state_nxt   = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
